cu_data_read_engine_control_ot: RTL
===================================

# cu_data_read_engine_control_ot

Parametrised successor to the compute unit's single-array read engine control. It splits the WED `array_send` stream into cacheline read commands, as before. It adds:
- a bounded outstanding-command window;
- a configurable burst gap;
- response filtering by `cu_id`;
- an explicit completion state machine.

It sits between the WED control and the read command arbiter, inside each compute unit.

## Interface
- `CU_READ_CONTROL_ID`, default `DATA_READ_CONTROL_ID`: `cu_id` stamped on commands; responses and data with any other `cu_id` are ignored.
- `MAX_OUTSTANDING`, default 16: maximum issued-but-unanswered commands (1..255).
- `CNT_W`, default `$clog2(MAX_OUTSTANDING+1)`: outstanding counter width.
- `clock` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enabled_in` in 1: block enable, registered twice internally.
- `wed_request_in` in `WEDInterface`: job descriptor, sampled once per job.
- `cu_configure` in 64: bits [0:2] select CABT, bit [3] selects `READ_CL_S` mode, bits [8:15] set the burst gap in cycles; latched only when nonzero.
- `read_response_in` in `ResponseBufferLine`: command responses.
- `read_data_0_in` / `read_data_1_in` in `ReadWriteDataLine`: returned data halves.
- `read_command_buffer_status`, `read_data_out_buffer_status` in `BufferStatus`: backpressure via `alfull`.
- `read_command_out` out `CommandBufferLine`: issued command, valid for one cycle.
- `read_data_0_out` / `read_data_1_out` out `ReadWriteDataLine`: filtered data.
- `read_job_counter_done` out `ARRAY_SIZE_BITS`: elements returned so far.
- `read_job_done` out 1: job complete, a level held until a new job or reset.
- `outstanding_count` out `CNT_W`: current outstanding commands, for debug.

## Operation
States:
- **IDLE**: wait for `enabled_cmd`, then go to WAIT_WED.
- **WAIT_WED**: when `wed_request_in.valid`, latch the WED and clear `next_offset`, the done counter and `read_job_done`.
  - `size_send==0`: go to DONE.
  - Otherwise: go to ISSUE.
- **ISSUE**: issue one command per cycle when all of the following hold:
  - `outstanding < MAX_OUTSTANDING`;
  - neither `alfull` is asserted;
  - the gap counter is 0.
- Per issued command:
  - `real_size = min(remaining, CACHELINE_ARRAY_NUM)`;
  - `address = array_send + next_offset`;
  - `next_offset += CACHELINE_SIZE`;
  - `remaining -= real_size`;
  - the gap counter loads `cu_configure[8:15]`.
- Command encoding:
  - bit3=1: `READ_CL_S` with size `12'h080`.
  - bit3=0: `READ_CL_NA` for full lines and `READ_PNA` for the tail line, with size `cmd_size_calculate(remaining)`.
  - Common fields: `cmd_type` = `CMD_READ`, `array_struct` = `READ_DATA`, `cacheline_offest` = 0, `address_offest` = `next_offset`, `abt` and `cmd.abt` = `map_CABT(cfg[0:2])`.
- When `remaining` reaches 0, go to DRAIN.
- **DRAIN**: when `outstanding==0`, go to DONE.
- **DONE**: assert `read_job_done`.
  - If the latched WED becomes invalid (WED deasserted), go to WAIT_WED.
  - If `enabled_in` falls, go to IDLE.
- Outstanding counter:
  - +1 on issue;
  - −1 on a latched valid response whose `cmd.cu_id` matches;
  - both in the same cycle: unchanged;
  - never underflows: a stray response at 0 is dropped and the counter stays 0.
- Done counter: adds the matching response's `cmd.real_size`, saturating at the all-ones value.
- Data path: registered pass-through, qualified by `valid` and a matching `cmd.cu_id`; non-matching data drives `valid=0`.
- Deasserting `enabled` mid-job:
  - freezes issue; no new commands are issued;
  - responses are still counted;
  - `outstanding_count` remains accurate.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, latched configuration 0.
- `enabled_in` to issue capability: 2 cycles (`enabled`, then `enabled_cmd`).
- Issue decision to `read_command_out.valid`: 2 register stages (latched command, then output register).
- `alfull` is sampled in the decision cycle. Up to 2 commands may therefore be in flight after it rises; consumers size for that.
- Response at input to `outstanding`/done counter update: 2 cycles (input latch, then update).
- `read_data_*_out`: 2 cycles after input.
- `read_job_done` rises the cycle after DRAIN sees `outstanding==0`.
- Gap value 0 allows back-to-back issue. Gap value g gives g idle cycles between commands.

## Structure
- Add to `CU_PKG`:
  - the `read_engine_state` enum (IDLE, WAIT_WED, ISSUE, DRAIN, DONE);
  - constant `READ_GAP_LSB`/`MSB` for the `cu_configure` field positions.
- Reuse from the packages: `CACHELINE_ARRAY_NUM`, `CACHELINE_SIZE`, `cmd_size_calculate` and `map_CABT`.
- One sub-module, `cu_outstanding_counter`, parameterised by MAX and width:
  - inputs: increment, decrement;
  - outputs: count, full, empty;
  - handles simultaneous increment/decrement and underflow protection.

## Test plan
- size_send=40, CACHELINE_ARRAY_NUM=16, bit3=0 →
  - three commands, at `array_send`, +128 and +256;
  - `real_size` 16, 16, 8; commands `READ_CL_NA`, `READ_CL_NA`, `READ_PNA`;
  - done counter=40 and `read_job_done`=1 after the three responses.
- MAX_OUTSTANDING=4, no responses, size_send=160 → exactly 4 commands issued, `outstanding_count`=4. Return one response → exactly one further command issues.
- Response coincides with an issue while outstanding=3 → `outstanding_count` stays 3.
- `alfull` held for 10 cycles mid-job → no new decisions during the hold; at most 2 trailing commands; issue resumes with addresses contiguous.
- Gap=3, bit3=1 → `READ_CL_S`, size `12'h080`, commands spaced 4 cycles apart.
- Responses and data with a foreign `cu_id`, plus rstn asserted mid-DRAIN:
  - foreign responses do not change the counters;
  - foreign data is output with `valid=0`;
  - reset clears all outputs immediately; the next WED restarts at offset 0.

Source files
------------

// File: rtl/cu_data_read_engine_control_ot_pkg.sv
// Types, constants and helpers shared by the read engine control and its
// outstanding-command counter.
package cu_data_read_engine_control_ot_pkg;

    localparam int unsigned ARRAY_SIZE_BITS     = 32;
    localparam int unsigned CACHELINE_ARRAY_NUM = 16;
    localparam int unsigned CACHELINE_SIZE      = 128;
    localparam int unsigned CU_ID_W             = 8;
    localparam int unsigned DATA_HALF_W         = 512;

    localparam logic [CU_ID_W-1:0] DATA_READ_CONTROL_ID = 8'h02;

    localparam int unsigned READ_CABT_LSB = 0;
    localparam int unsigned READ_CABT_MSB = 2;
    localparam int unsigned READ_CL_S_BIT = 3;
    localparam int unsigned READ_GAP_LSB  = 8;
    localparam int unsigned READ_GAP_MSB  = 15;

    typedef enum logic [2:0] {IDLE, WAIT_WED, ISSUE, DRAIN, DONE} read_engine_state;

    typedef enum logic [3:0] {
        NOP, READ_CL_S, READ_CL_NA, READ_PNA, WRITE_NA, WRITE_MS
    } afu_command_t;

    typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE} cmd_type_t;
    typedef enum logic [1:0] {STRUCT_INVALID, READ_DATA, WRITE_DATA} array_struct_t;
    typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_behavior_t;

    typedef struct packed {
        logic [CU_ID_W-1:0]    cu_id;
        cmd_type_t             cmd_type;
        array_struct_t         array_struct;
        logic [7:0]            real_size;
        logic [7:0]            cacheline_offest;
        logic [63:0]           address_offest;
        trans_order_behavior_t abt;
    } CommandTagLine;

    typedef struct packed {
        logic                  valid;
        afu_command_t          command;
        logic [63:0]           address;
        logic [11:0]           size;
        CommandTagLine         cmd;
        trans_order_behavior_t abt;
    } CommandBufferLine;

    typedef struct packed {
        logic          valid;
        CommandTagLine cmd;
    } ResponseBufferLine;

    typedef struct packed {
        logic                   valid;
        CommandTagLine          cmd;
        logic [DATA_HALF_W-1:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;

    typedef struct packed {
        logic                       valid;
        logic [63:0]                array_send;
        logic [ARRAY_SIZE_BITS-1:0] size_send;
    } WEDInterface;

    // Byte count of a read: a full line, or 8 bytes per element for a tail.
    function automatic logic [11:0] cmd_size_calculate(input logic [ARRAY_SIZE_BITS-1:0] remaining);
        if (remaining >= ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM)) begin
            return 12'h080;
        end
        return 12'({remaining[8:0], 3'b000});
    endfunction

    function automatic trans_order_behavior_t map_CABT(input logic [2:0] cabt);
        case (cabt)
            3'd1:    return ABORT;
            3'd2:    return PAGE;
            3'd3:    return PREF;
            3'd4:    return SPEC;
            default: return STRICT;
        endcase
    endfunction

endpackage

// File: rtl/cu_data_read_engine_control_ot_outstanding_counter.sv
// Issued-but-unanswered command counter; saturates at MAX_COUNT, never underflows.
module cu_outstanding_counter
    import cu_data_read_engine_control_ot_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             increment_i,
    input  logic             decrement_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             do_inc, do_dec;

    assign full_o  = (count_q >= CNT_W'(MAX_COUNT));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        do_inc  = increment_i && !full_o;
        do_dec  = decrement_i && !empty_o;
        count_d = count_q;
        if (do_inc && !do_dec) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_inc && do_dec) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cu_data_read_engine_control_ot.sv
// Read engine control: splits one WED array into cacheline reads with a bounded
// outstanding window, a burst gap, cu_id response filtering and a completion FSM.
module cu_data_read_engine_control_ot
    import cu_data_read_engine_control_ot_pkg::*;
#(
    parameter logic [CU_ID_W-1:0] CU_READ_CONTROL_ID = DATA_READ_CONTROL_ID,
    parameter int unsigned        MAX_OUTSTANDING    = 16,
    parameter int unsigned        CNT_W              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       enabled_in,
    input  WEDInterface                wed_request_in,
    input  logic [63:0]                cu_configure,
    input  ResponseBufferLine          read_response_in,
    input  ReadWriteDataLine           read_data_0_in,
    input  ReadWriteDataLine           read_data_1_in,
    input  BufferStatus                read_command_buffer_status,
    input  BufferStatus                read_data_out_buffer_status,
    output CommandBufferLine           read_command_out,
    output ReadWriteDataLine           read_data_0_out,
    output ReadWriteDataLine           read_data_1_out,
    output logic [ARRAY_SIZE_BITS-1:0] read_job_counter_done,
    output logic                       read_job_done,
    output logic [CNT_W-1:0]           outstanding_count
);

    localparam logic [ARRAY_SIZE_BITS-1:0] LineElems = ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM);

    read_engine_state           state_q;
    logic                       enabled_q, enabled_cmd_q;
    logic [2:0]                 cabt_q;
    logic                       cl_s_q;
    logic [7:0]                 gap_cfg_q, gap_q;
    logic [63:0]                array_send_q, next_offset_q;
    logic [ARRAY_SIZE_BITS-1:0] remaining_q;
    CommandBufferLine           cmd_latched_q, next_cmd;
    ResponseBufferLine          resp_q;
    ReadWriteDataLine           data_0_q, data_1_q;
    logic                       issue, resp_hit, full, empty;
    logic [7:0]                 real_size;
    logic [ARRAY_SIZE_BITS:0]   done_sum;
    logic                       unused_fields;

    function automatic ReadWriteDataLine filter_data(input ReadWriteDataLine d);
        filter_data       = d;
        filter_data.valid = d.valid && (d.cmd.cu_id == CU_READ_CONTROL_ID);
    endfunction

    assign issue = (state_q == ISSUE) && enabled_cmd_q && !full
                   && !read_command_buffer_status.alfull && !read_data_out_buffer_status.alfull
                   && (gap_q == '0) && (remaining_q != '0);

    // Empty gate drops stray responses so neither counter moves for them.
    assign resp_hit = resp_q.valid && (resp_q.cmd.cu_id == CU_READ_CONTROL_ID) && !empty;

    assign real_size = (remaining_q < LineElems) ? remaining_q[7:0] : 8'(CACHELINE_ARRAY_NUM);
    assign done_sum  = {1'b0, read_job_counter_done}
                       + {{(ARRAY_SIZE_BITS - 7){1'b0}}, resp_q.cmd.real_size};

    assign unused_fields = ^{resp_q.cmd.cmd_type, resp_q.cmd.array_struct,
                             resp_q.cmd.cacheline_offest, resp_q.cmd.address_offest,
                             resp_q.cmd.abt, read_command_buffer_status.full,
                             read_command_buffer_status.empty, read_data_out_buffer_status.full,
                             read_data_out_buffer_status.empty};

    always_comb begin
        next_cmd                       = '0;
        next_cmd.valid                 = 1'b1;
        next_cmd.address               = array_send_q + next_offset_q;
        next_cmd.abt                   = map_CABT(cabt_q);
        next_cmd.cmd.cu_id             = CU_READ_CONTROL_ID;
        next_cmd.cmd.cmd_type          = CMD_READ;
        next_cmd.cmd.array_struct      = READ_DATA;
        next_cmd.cmd.real_size         = real_size;
        next_cmd.cmd.cacheline_offest  = '0;
        next_cmd.cmd.address_offest    = next_offset_q;
        next_cmd.cmd.abt               = map_CABT(cabt_q);
        if (cl_s_q) begin
            next_cmd.command = READ_CL_S;
            next_cmd.size    = 12'h080;
        end else begin
            next_cmd.command = (remaining_q < LineElems) ? READ_PNA : READ_CL_NA;
            next_cmd.size    = cmd_size_calculate(remaining_q);
        end
    end

    cu_outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_W     (CNT_W)
    ) u_outstanding (
        .clock       (clock),
        .rstn        (rstn),
        .increment_i (issue),
        .decrement_i (resp_hit),
        .count_o     (outstanding_count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q               <= IDLE;
            enabled_q             <= 1'b0;
            enabled_cmd_q         <= 1'b0;
            cabt_q                <= '0;
            cl_s_q                <= 1'b0;
            gap_cfg_q             <= '0;
            gap_q                 <= '0;
            array_send_q          <= '0;
            next_offset_q         <= '0;
            remaining_q           <= '0;
            cmd_latched_q         <= '0;
            resp_q                <= '0;
            data_0_q              <= '0;
            data_1_q              <= '0;
            read_command_out      <= '0;
            read_data_0_out       <= '0;
            read_data_1_out       <= '0;
            read_job_counter_done <= '0;
            read_job_done         <= 1'b0;
        end else begin
            enabled_q     <= enabled_in;
            enabled_cmd_q <= enabled_q;
            if (cu_configure != '0) begin
                cabt_q    <= cu_configure[READ_CABT_MSB:READ_CABT_LSB];
                cl_s_q    <= cu_configure[READ_CL_S_BIT];
                gap_cfg_q <= cu_configure[READ_GAP_MSB:READ_GAP_LSB];
            end

            resp_q          <= read_response_in;
            data_0_q        <= read_data_0_in;
            data_1_q        <= read_data_1_in;
            read_data_0_out <= filter_data(data_0_q);
            read_data_1_out <= filter_data(data_1_q);

            cmd_latched_q    <= issue ? next_cmd : '0;
            read_command_out <= cmd_latched_q;

            if (issue) begin
                gap_q <= gap_cfg_q;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 8'd1;
            end

            if (resp_hit) begin
                read_job_counter_done <= done_sum[ARRAY_SIZE_BITS] ? '1
                                         : done_sum[ARRAY_SIZE_BITS-1:0];
            end

            case (state_q)
                IDLE: begin
                    if (enabled_cmd_q) state_q <= WAIT_WED;
                end
                WAIT_WED: begin
                    if (wed_request_in.valid) begin
                        array_send_q          <= wed_request_in.array_send;
                        remaining_q           <= wed_request_in.size_send;
                        next_offset_q         <= '0;
                        read_job_counter_done <= '0;
                        read_job_done         <= (wed_request_in.size_send == '0);
                        state_q <= (wed_request_in.size_send == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        next_offset_q <= next_offset_q + 64'(CACHELINE_SIZE);
                        remaining_q   <= remaining_q - ARRAY_SIZE_BITS'(real_size);
                        if (remaining_q == ARRAY_SIZE_BITS'(real_size)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_q       <= DONE;
                        read_job_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!enabled_cmd_q) begin
                        state_q <= IDLE;
                    end else if (!wed_request_in.valid) begin
                        state_q <= WAIT_WED;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
